// File: rtl/vm_change_if.sv
// Bus between the vending core and the change scheduler.
// The core drives the i_* signals; the scheduler drives the o_* signals.
interface vm_change_if #(
    parameter int BAL_W = 16,
    parameter int CNT_W = 8
);
    logic [BAL_W-1:0] i_balance;
    logic [2:0]       i_input_coin;
    logic             i_activity;
    logic             i_trigger_return;
    logic [2:0]       o_return_coin;
    logic [BAL_W-1:0] o_return_value;
    logic             o_busy;
    logic             o_done;
    logic             o_stuck;
    logic [BAL_W-1:0] o_residual;
    logic [CNT_W-1:0] o_cnt_100;
    logic [CNT_W-1:0] o_cnt_500;
    logic [CNT_W-1:0] o_cnt_1000;

    modport master (
        output i_balance, i_input_coin, i_activity, i_trigger_return,
        input  o_return_coin, o_return_value, o_busy, o_done, o_stuck, o_residual,
               o_cnt_100, o_cnt_500, o_cnt_1000
    );

    modport slave (
        input  i_balance, i_input_coin, i_activity, i_trigger_return,
        output o_return_coin, o_return_value, o_busy, o_done, o_stuck, o_residual,
               o_cnt_100, o_cnt_500, o_cnt_1000
    );
endinterface

// File: rtl/vm_change_scheduler.sv
// Coin-return controller: starts a return on request or idle timeout, then pays out the
// latched balance one coin per cycle, largest coin first, tracking per-coin inventory.
module vm_change_scheduler #(
    parameter int BAL_W     = 16,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 10,
    parameter int INIT_100  = 10,
    parameter int INIT_500  = 10,
    parameter int INIT_1000 = 10
) (
    input  logic       clk,
    input  logic       reset,
    vm_change_if.slave bus
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [BAL_W-1:0] BAL_ZERO  = {BAL_W{1'b0}};
    localparam logic [BAL_W-1:0] COIN_100  = BAL_W'(100);
    localparam logic [BAL_W-1:0] COIN_500  = BAL_W'(500);
    localparam logic [BAL_W-1:0] COIN_1000 = BAL_W'(1000);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t           state_r;
    logic [TMR_W-1:0] timer_r;
    logic [BAL_W-1:0] rem_r;
    logic             stuck_r;
    logic [2:0]       return_coin_r;
    logic [BAL_W-1:0] return_value_r;
    logic             busy_r;
    logic             done_r;
    logic             stuck_out_r;
    logic [BAL_W-1:0] residual_r;
    logic [CNT_W-1:0] cnt_100_r;
    logic [CNT_W-1:0] cnt_500_r;
    logic [CNT_W-1:0] cnt_1000_r;

    logic [2:0]       pick_s;
    logic [BAL_W-1:0] pick_value_s;
    logic [2:0]       disp_s;
    logic             start_s;

    function automatic logic [BAL_W-1:0] coin_value(input logic [2:0] coin);
        logic [BAL_W-1:0] value;
        case (coin)
            3'b001:  value = COIN_100;
            3'b010:  value = COIN_500;
            3'b100:  value = COIN_1000;
            default: value = BAL_ZERO;
        endcase
        return value;
    endfunction

    // Insert and dispense of the same type cancel; inserts saturate at the counter ceiling.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic ins, input logic disp);
        logic [CNT_W-1:0] res;
        case ({ins, disp})
            2'b10:   res = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            2'b01:   res = cnt - CNT_W'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Largest coin that fits in the remainder and is still in stock.
    always_comb begin
        pick_s = 3'b000;
        if ((cnt_1000_r != CNT_ZERO) && (rem_r >= COIN_1000)) begin
            pick_s = 3'b100;
        end else if ((cnt_500_r != CNT_ZERO) && (rem_r >= COIN_500)) begin
            pick_s = 3'b010;
        end else if ((cnt_100_r != CNT_ZERO) && (rem_r >= COIN_100)) begin
            pick_s = 3'b001;
        end else begin
            pick_s = 3'b000;
        end
    end

    // Dispense strobe and return-start decision for the current cycle.
    always_comb begin
        pick_value_s = coin_value(pick_s);
        disp_s       = (state_r == DISPENSE) ? pick_s : 3'b000;
        start_s      = (bus.i_balance != BAL_ZERO) &&
                       (bus.i_trigger_return || ((timer_r == TMR_LAST) && !bus.i_activity));
    end

    // Return FSM with registered outputs and coin inventory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            timer_r        <= {TMR_W{1'b0}};
            rem_r          <= BAL_ZERO;
            stuck_r        <= 1'b0;
            return_coin_r  <= 3'b000;
            return_value_r <= BAL_ZERO;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            stuck_out_r    <= 1'b0;
            residual_r     <= BAL_ZERO;
            cnt_100_r      <= CNT_W'(INIT_100);
            cnt_500_r      <= CNT_W'(INIT_500);
            cnt_1000_r     <= CNT_W'(INIT_1000);
        end else begin
            cnt_100_r      <= next_count(cnt_100_r,  bus.i_input_coin[0], disp_s[0]);
            cnt_500_r      <= next_count(cnt_500_r,  bus.i_input_coin[1], disp_s[1]);
            cnt_1000_r     <= next_count(cnt_1000_r, bus.i_input_coin[2], disp_s[2]);
            return_coin_r  <= 3'b000;
            return_value_r <= BAL_ZERO;
            done_r         <= 1'b0;
            stuck_out_r    <= 1'b0;
            residual_r     <= BAL_ZERO;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= DISPENSE;
                        rem_r   <= bus.i_balance;
                        timer_r <= {TMR_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else if (bus.i_activity || (bus.i_balance == BAL_ZERO)) begin
                        timer_r <= {TMR_W{1'b0}};
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                DISPENSE: begin
                    if (pick_s == 3'b000) begin
                        state_r <= DONE;
                        stuck_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        return_coin_r  <= pick_s;
                        return_value_r <= pick_value_s;
                        rem_r          <= rem_r - pick_value_s;
                        if (rem_r == pick_value_s) begin
                            state_r <= DONE;
                            stuck_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= DISPENSE;
                        end
                    end
                end
                DONE: begin
                    done_r      <= 1'b1;
                    stuck_out_r <= stuck_r;
                    residual_r  <= rem_r;
                    state_r     <= IDLE;
                    timer_r     <= {TMR_W{1'b0}};
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= {TMR_W{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_return_coin  = return_coin_r;
    assign bus.o_return_value = return_value_r;
    assign bus.o_busy         = busy_r;
    assign bus.o_done         = done_r;
    assign bus.o_stuck        = stuck_out_r;
    assign bus.o_residual     = residual_r;
    assign bus.o_cnt_100      = cnt_100_r;
    assign bus.o_cnt_500      = cnt_500_r;
    assign bus.o_cnt_1000     = cnt_1000_r;
endmodule

// File: tb/tb_vm_change_scheduler.sv
// Directed bench for vm_change_scheduler: default-inventory instance u0 and a
// low-inventory instance u1 (1x1000, 0x500, 2x100) sharing clock and reset.
module tb_vm_change_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vm_change_if #(.BAL_W(16), .CNT_W(8)) bus0 ();
    vm_change_if #(.BAL_W(16), .CNT_W(8)) bus1 ();

    vm_change_scheduler #(
        .BAL_W(16), .CNT_W(8), .TIMEOUT(10),
        .INIT_100(10), .INIT_500(10), .INIT_1000(10)
    ) u0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    vm_change_scheduler #(
        .BAL_W(16), .CNT_W(8), .TIMEOUT(10),
        .INIT_100(2), .INIT_500(0), .INIT_1000(1)
    ) u1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [2:0] coin, input int value,
                        input logic busy, input logic done);
        check({tag, "_coin"},  32'(bus0.o_return_coin),  32'(coin));
        check({tag, "_value"}, 32'(bus0.o_return_value), 32'(value));
        check({tag, "_busy"},  32'(bus0.o_busy),         32'(busy));
        check({tag, "_done"},  32'(bus0.o_done),         32'(done));
    endtask

    task automatic chk1(input string tag, input logic [2:0] coin, input int value,
                        input logic busy, input logic done);
        check({tag, "_coin"},  32'(bus1.o_return_coin),  32'(coin));
        check({tag, "_value"}, 32'(bus1.o_return_value), 32'(value));
        check({tag, "_busy"},  32'(bus1.o_busy),         32'(busy));
        check({tag, "_done"},  32'(bus1.o_done),         32'(done));
    endtask

    task automatic cnt0(input string tag, input int c100, input int c500, input int c1000);
        check({tag, "_cnt100"},  32'(bus0.o_cnt_100),  32'(c100));
        check({tag, "_cnt500"},  32'(bus0.o_cnt_500),  32'(c500));
        check({tag, "_cnt1000"}, 32'(bus0.o_cnt_1000), 32'(c1000));
    endtask

    initial begin
        reset = 1'b1;
        bus0.i_balance = 16'd0; bus0.i_input_coin = 3'b000;
        bus0.i_activity = 1'b0; bus0.i_trigger_return = 1'b0;
        bus1.i_balance = 16'd0; bus1.i_input_coin = 3'b000;
        bus1.i_activity = 1'b0; bus1.i_trigger_return = 1'b0;
        step();
        step();

        // Reset state
        chk0("rst", 3'b000, 0, 1'b0, 1'b0);
        check("rst_stuck", 32'(bus0.o_stuck), 32'd0);
        check("rst_resid", 32'(bus0.o_residual), 32'd0);
        cnt0("rst", 10, 10, 10);
        check("rst_u1_cnt100",  32'(bus1.o_cnt_100),  32'd2);
        check("rst_u1_cnt500",  32'(bus1.o_cnt_500),  32'd0);
        check("rst_u1_cnt1000", 32'(bus1.o_cnt_1000), 32'd1);
        reset = 1'b0;

        // Trigger with zero balance is ignored
        bus0.i_trigger_return = 1'b1;
        step();
        chk0("zero_trig", 3'b000, 0, 1'b0, 1'b0);
        bus0.i_trigger_return = 1'b0;
        step();
        chk0("zero_trig2", 3'b000, 0, 1'b0, 1'b0);

        // Explicit return of 2300
        bus0.i_balance = 16'd2300; bus0.i_trigger_return = 1'b1;
        step();
        chk0("t1_start", 3'b000, 0, 1'b1, 1'b0);
        bus0.i_trigger_return = 1'b0;
        step(); chk0("t1_c1", 3'b100, 1000, 1'b1, 1'b0);
        bus0.i_balance = 16'd0;
        step(); chk0("t1_c2", 3'b100, 1000, 1'b1, 1'b0);
        step(); chk0("t1_c3", 3'b001, 100, 1'b1, 1'b0);
        step(); chk0("t1_c4", 3'b001, 100, 1'b1, 1'b0);
        step(); chk0("t1_c5", 3'b001, 100, 1'b0, 1'b0);
        step(); chk0("t1_done", 3'b000, 0, 1'b0, 1'b1);
        check("t1_stuck", 32'(bus0.o_stuck), 32'd0);
        check("t1_resid", 32'(bus0.o_residual), 32'd0);
        cnt0("t1", 7, 10, 8);
        step(); chk0("t1_after", 3'b000, 0, 1'b0, 1'b0);

        // Auto return of 700 after 10 idle cycles
        bus0.i_balance = 16'd700;
        for (int i = 0; i < 9; i++) begin
            step(); chk0("t2_idle", 3'b000, 0, 1'b0, 1'b0);
        end
        step(); chk0("t2_start", 3'b000, 0, 1'b1, 1'b0);
        step(); chk0("t2_c1", 3'b010, 500, 1'b1, 1'b0);
        bus0.i_balance = 16'd0;
        step(); chk0("t2_c2", 3'b001, 100, 1'b1, 1'b0);
        step(); chk0("t2_c3", 3'b001, 100, 1'b0, 1'b0);
        step(); chk0("t2_done", 3'b000, 0, 1'b0, 1'b1);
        check("t2_stuck", 32'(bus0.o_stuck), 32'd0);
        cnt0("t2", 5, 9, 8);

        // Activity at idle cycle 8 restarts the timer
        bus0.i_balance = 16'd600;
        for (int i = 0; i < 7; i++) begin
            step(); chk0("t3_idle_a", 3'b000, 0, 1'b0, 1'b0);
        end
        bus0.i_activity = 1'b1;
        step(); chk0("t3_act", 3'b000, 0, 1'b0, 1'b0);
        bus0.i_activity = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(); chk0("t3_idle_b", 3'b000, 0, 1'b0, 1'b0);
        end
        step(); chk0("t3_start", 3'b000, 0, 1'b1, 1'b0);

        // Insert a 500 in the cycle a 500 is dispensed
        bus0.i_input_coin = 3'b010;
        step(); chk0("t5_c1", 3'b010, 500, 1'b1, 1'b0);
        check("t5_cnt500", 32'(bus0.o_cnt_500), 32'd9);
        bus0.i_input_coin = 3'b000;
        bus0.i_balance = 16'd0;
        step(); chk0("t3_c2", 3'b001, 100, 1'b0, 1'b0);
        step(); chk0("t3_done", 3'b000, 0, 1'b0, 1'b1);
        cnt0("t3", 4, 9, 8);

        // Plain insertion while idle
        bus0.i_input_coin = 3'b100;
        step();
        bus0.i_input_coin = 3'b000;
        cnt0("ins", 4, 9, 9);

        // Balance not a multiple of 100
        bus0.i_balance = 16'd150; bus0.i_trigger_return = 1'b1;
        step(); chk0("odd_start", 3'b000, 0, 1'b1, 1'b0);
        bus0.i_trigger_return = 1'b0; bus0.i_balance = 16'd0;
        step(); chk0("odd_c1", 3'b001, 100, 1'b1, 1'b0);
        step(); chk0("odd_nocoin", 3'b000, 0, 1'b0, 1'b0);
        step(); chk0("odd_done", 3'b000, 0, 1'b0, 1'b1);
        check("odd_stuck", 32'(bus0.o_stuck), 32'd1);
        check("odd_resid", 32'(bus0.o_residual), 32'd50);
        cnt0("odd", 3, 9, 9);

        // Reset in the middle of a 4800 return
        bus0.i_balance = 16'd4800; bus0.i_trigger_return = 1'b1;
        step(); chk0("t6_start", 3'b000, 0, 1'b1, 1'b0);
        bus0.i_trigger_return = 1'b0;
        step(); chk0("t6_c1", 3'b100, 1000, 1'b1, 1'b0);
        step(); chk0("t6_c2", 3'b100, 1000, 1'b1, 1'b0);
        reset = 1'b1;
        step(); chk0("t6_rst", 3'b000, 0, 1'b0, 1'b0);
        check("t6_resid", 32'(bus0.o_residual), 32'd0);
        cnt0("t6", 10, 10, 10);
        reset = 1'b0; bus0.i_balance = 16'd0;
        step(); chk0("t6_idle", 3'b000, 0, 1'b0, 1'b0);

        // Limited inventory: 1500 with 1x1000, 0x500, 2x100
        bus1.i_balance = 16'd1500; bus1.i_trigger_return = 1'b1;
        step(); chk1("t4_start", 3'b000, 0, 1'b1, 1'b0);
        bus1.i_trigger_return = 1'b0; bus1.i_balance = 16'd0;
        step(); chk1("t4_c1", 3'b100, 1000, 1'b1, 1'b0);
        step(); chk1("t4_c2", 3'b001, 100, 1'b1, 1'b0);
        step(); chk1("t4_c3", 3'b001, 100, 1'b1, 1'b0);
        step(); chk1("t4_nocoin", 3'b000, 0, 1'b0, 1'b0);
        step(); chk1("t4_done", 3'b000, 0, 1'b0, 1'b1);
        check("t4_stuck", 32'(bus1.o_stuck), 32'd1);
        check("t4_resid", 32'(bus1.o_residual), 32'd300);
        check("t4_cnt100",  32'(bus1.o_cnt_100),  32'd0);
        check("t4_cnt1000", 32'(bus1.o_cnt_1000), 32'd0);
        step(); chk1("t4_after", 3'b000, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
